wslce_correlator: RTL and testbench
===================================

WSLCE_CORRELATOR -- requirements
Module: wslce_correlator

Interface
REQ-001 SHALL provide parameter N, default 23, code length in chips (prime).
REQ-002 SHALL provide parameter CODE, default 23'h2C4372, the WSLCE reference word, 10 ones, transmitted bit N-1 first.
REQ-003 SHALL provide parameter THRESH, default 21, minimum agreement count that declares a peak.
REQ-004 SHALL provide parameter MISS_MAX, default 2, consecutive missed expected peaks that drop lock.
REQ-005 SHALL have ports: clk input 1 rising-edge clock; rst input 1 reset.
REQ-006 SHALL have ports: din input 1 received chip; din_valid input 1 chip qualifier.
REQ-007 SHALL have ports: match output 1 one-cycle peak pulse; score output W agreement count, W=$clog2(N+1), 5 for N=23.
REQ-008 SHALL have ports: locked output 1 lock status; phase output W chip index since last peak, 0..N-1.
REQ-009 SHALL use one clock, clk; rst SHALL be asynchronous and active-high.

Function
REQ-010 SHALL shift accepted chips in as sr <= {sr[N-2:0], din} on each posedge with din_valid=1; sr SHALL hold when din_valid=0.
REQ-011 SHALL count accepted chips in a fill counter saturating at N; the evaluation flag SHALL be set only for accepted chips once the fill counter reaches N, the Nth chip included.
REQ-012 SHALL register score = N - popcount(sr ^ CODE) one clock after the shift edge, and only on evaluation cycles; score SHALL hold otherwise.
REQ-013 SHALL assert match for exactly one cycle, with the same timing as the score update, when the evaluated score >= THRESH. Latency from the accepting edge to match high SHALL be 2 clk edges.
REQ-014 SHALL evaluate back-to-back valid chips at full rate with no stalls; there is no backpressure.
REQ-015 SHALL implement the FSM states SEARCH and LOCKED. In SEARCH, a match SHALL move the FSM to LOCKED, with phase <= 0 and miss count <= 0.
REQ-016 In LOCKED, each evaluation SHALL increment phase. At phase==N-1 (the expected peak), the evaluation SHALL wrap phase to 0.
REQ-017 At an expected peak with a match, the block SHALL clear the miss count. Without a match, it SHALL increment the miss count, and on reaching MISS_MAX SHALL move to SEARCH with phase 0.
REQ-018 In LOCKED, a match at a non-expected phase SHALL still pulse match and SHALL NOT alter phase, lock or miss count.
REQ-019 locked SHALL be 1 iff the state is LOCKED; phase SHALL read 0 in SEARCH.

Reset
REQ-020 On rst=1 the block SHALL asynchronously clear sr, the fill counter, the miss count, score, phase, match and locked, and set state SEARCH.
REQ-021 Reset mid-frame SHALL discard all chips received; N fresh valid chips SHALL be required before the next evaluation.

Configuration
REQ-022 With macro WSLCE_INV_DET_EN defined, the block SHALL add output match_inv (1 bit). match_inv SHALL pulse with the same timing as match when the score <= N-THRESH, i.e. an inverted-polarity code is detected. An inverted peak SHALL count as a match for lock and expected-peak purposes.
REQ-023 Without WSLCE_INV_DET_EN, match_inv SHALL NOT exist, and a score <= N-THRESH SHALL have no effect.

Verification
REQ-024 Reset, then CODE 23'h2C4372 sent MSB-first with din_valid=1 continuously -> 2 edges after the 23rd chip: match=1 for 1 cycle, score=23, locked=1, phase=0.
REQ-025 CODE sent 3 periods back-to-back -> match exactly every 23 chips, locked stays 1, and phase counts 0..22 and wraps.
REQ-026 CODE sent with 2 chips flipped -> score=21 and match=1; with 3 chips flipped -> score=20, no match, locked=0.
REQ-027 Locked, then all-zero chips sent -> score=13 at the expected peaks; locked falls at the 2nd missed expected peak, 46 chips after the last peak.
REQ-028 CODE sent with 1-3 idle cycles between chips -> same score and match results as REQ-024; score holds during idle cycles; rst pulsed after 10 chips -> all outputs 0, and no match until 23 new chips are received.
REQ-029 With WSLCE_INV_DET_EN defined, ~CODE (23'h53BC8D) sent -> score=0, match_inv=1, match=0, locked=1.

Source files
------------

// File: rtl/wslce_correlator.sv
// WSLCE sync-word correlator with peak tracking lock FSM.
// Optional inverted-polarity detection: define WSLCE_INV_DET_EN.
module wslce_correlator #(
  parameter int            N        = 23,
  parameter logic [N-1:0]  CODE     = 23'h2C4372,
  parameter int            THRESH   = 21,
  parameter int            MISS_MAX = 2,
  localparam int           W        = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  input  logic         din_valid,
  output logic         match,
`ifdef WSLCE_INV_DET_EN
  output logic         match_inv,
`endif
  output logic [W-1:0] score,
  output logic         locked,
  output logic [W-1:0] phase
);

  localparam int MW = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

  localparam logic [W-1:0]  NW  = W'(N);
  localparam logic [W-1:0]  N1  = W'(N - 1);
  localparam logic [W-1:0]  TH  = W'(THRESH);
  localparam logic [W-1:0]  LO  = W'(N - THRESH);
  localparam logic [MW-1:0] ML  = MW'(MISS_MAX - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  sr;
  logic [W-1:0]  fill;
  logic          eval;
  logic [W-1:0]  ones;
  logic [W-1:0]  score_nx;
  logic          hit_pos;
  logic          hit_neg;
  logic          hit;
  logic          expected;
  logic [W-1:0]  phase_nx;
  logic [MW-1:0] miss;
  logic [MW-1:0] miss_nx;

  // Chip shift register, fill count and evaluation flag for accepted chips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      fill <= '0;
      eval <= 1'b0;
    end else begin
      eval <= 1'b0;
      if (din_valid) begin
        sr   <= {sr[N-2:0], din};
        eval <= (fill >= N1);
        if (fill != NW)
          fill <= fill + 1'b1;
      end
    end
  end

  // Agreement count: disagreements are popcount of window XOR code.
  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++)
      ones = ones + W'(sr[i] ^ CODE[i]);
    score_nx = NW - ones;
  end

  // Peak decisions for the window being evaluated this cycle.
  always_comb begin
    hit_pos = (score_nx >= TH);
`ifdef WSLCE_INV_DET_EN
    hit_neg = (score_nx <= LO);
`else
    hit_neg = 1'b0;
`endif
    hit      = eval && (hit_pos || hit_neg);
    expected = (phase == N1);
  end

  // Registered score and one-cycle peak pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score <= '0;
      match <= 1'b0;
`ifdef WSLCE_INV_DET_EN
      match_inv <= 1'b0;
`endif
    end else begin
      if (eval)
        score <= score_nx;
      match <= eval && hit_pos;
`ifdef WSLCE_INV_DET_EN
      match_inv <= eval && hit_neg;
`endif
    end
  end

  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= SEARCH;
    else
      state <= state_nx;
  end

  // Lock next state: acquire on any peak, drop after too many misses.
  always_comb begin
    state_nx = state;
    case (state)
      SEARCH: begin
        if (hit)
          state_nx = LOCKED;
      end
      LOCKED: begin
        if (eval && expected && !hit && miss == ML)
          state_nx = SEARCH;
      end
      default: state_nx = SEARCH;
    endcase
  end

  // Lock status output decode.
  always_comb begin
    locked = (state == LOCKED);
  end

  // Phase and miss bookkeeping, advanced only on evaluations.
  always_comb begin
    phase_nx = phase;
    miss_nx  = miss;
    if (eval) begin
      case (state)
        SEARCH: begin
          phase_nx = '0;
          if (hit)
            miss_nx = '0;
        end
        LOCKED: begin
          if (expected) begin
            phase_nx = '0;
            if (hit || miss == ML)
              miss_nx = '0;
            else
              miss_nx = miss + 1'b1;
          end else begin
            phase_nx = phase + 1'b1;
          end
        end
        default: begin
          phase_nx = '0;
          miss_nx  = '0;
        end
      endcase
    end
  end

  // Phase and miss registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      miss  <= '0;
    end else begin
      phase <= phase_nx;
      miss  <= miss_nx;
    end
  end

endmodule

// File: tb/tb_wslce_correlator.sv
// Bench for wslce_correlator: behavioural model feeds a scoreboard.
// Inverted detection cases are built when WSLCE_INV_DET_EN is defined.
module tb_wslce_correlator;

  localparam int N = 23;
  localparam logic [N-1:0] CODE = 23'h2C4372;
  localparam int THRESH = 21;
  localparam int MISS_MAX = 2;
  localparam int W = 5;

  typedef struct {
    int sc;
    int m;
    int mi;
    int lk;
    int ph;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic match;
  logic match_inv;
  logic [W-1:0] score;
  logic locked;
  logic [W-1:0] phase;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_match = 0;
  int n_inv = 0;

  exp_t q[$];
  logic [N-1:0] msr;
  int mfill, mlk, mph, mmiss;
  int e_sc, e_lk, e_ph;

  wslce_correlator dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .match(match),
`ifdef WSLCE_INV_DET_EN
    .match_inv(match_inv),
`endif
    .score(score),
    .locked(locked),
    .phase(phase)
  );

`ifndef WSLCE_INV_DET_EN
  assign match_inv = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: pop the expectation due this cycle, compare every cycle.
  initial begin
    exp_t e;
    int em, emi;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      em = 0;
      emi = 0;
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("stale_entry", q[0].due, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        e_sc = e.sc;
        e_lk = e.lk;
        e_ph = e.ph;
        em = e.m;
        emi = e.mi;
      end
      if (match === 1'b1) n_match++;
      if (match_inv === 1'b1) n_inv++;
      chk("match", 32'(match), em);
      chk("match_inv", 32'(match_inv), emi);
      chk("score", 32'(score), e_sc);
      chk("locked", 32'(locked), e_lk);
      chk("phase", 32'(phase), e_ph);
    end
  end

  task automatic model_accept(logic b);
    exp_t e;
    int sc, m, mi, hit;
    msr = {msr[N-2:0], b};
    if (mfill < N) mfill++;
    if (mfill == N) begin
      sc = N - $countones(msr ^ CODE);
      m = (sc >= THRESH) ? 1 : 0;
`ifdef WSLCE_INV_DET_EN
      mi = (sc <= N - THRESH) ? 1 : 0;
`else
      mi = 0;
`endif
      hit = m | mi;
      if (mlk == 0) begin
        if (hit != 0) begin
          mlk = 1;
          mph = 0;
          mmiss = 0;
        end
      end else if (mph == N - 1) begin
        mph = 0;
        if (hit != 0) mmiss = 0;
        else begin
          mmiss++;
          if (mmiss == MISS_MAX) begin
            mlk = 0;
            mmiss = 0;
          end
        end
      end else begin
        mph++;
      end
      e.sc = sc;
      e.m = m;
      e.mi = mi;
      e.lk = mlk;
      e.ph = mph;
      e.due = cyc + 2;
      q.push_back(e);
    end
  endtask

  task automatic send(logic b);
    @(negedge clk);
    din = b;
    din_valid = 1'b1;
    model_accept(b);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      din = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_word(logic [N-1:0] w, bit gaps);
    for (int i = N - 1; i >= 0; i--) begin
      send(w[i]);
      if (gaps) idle($urandom_range(1, 3));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    q.delete();
    msr = '0;
    mfill = 0;
    mlk = 0;
    mph = 0;
    mmiss = 0;
    e_sc = 0;
    e_lk = 0;
    e_ph = 0;
    #1;
    chk("rst_match", 32'(match), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_phase", 32'(phase), 0);
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    logic [N-1:0] w;
    msr = '0;
    mfill = 0;
    mlk = 0;
    mph = 0;
    mmiss = 0;
    e_sc = 0;
    e_lk = 0;
    e_ph = 0;
    do_reset();

    // Single clean code word.
    n0 = n_match;
    send_word(CODE, 1'b0);
    idle(3);
    chk("first_peaks", n_match - n0, 1);
    chk("first_score", 32'(score), 23);
    chk("first_locked", 32'(locked), 1);
    chk("first_phase", 32'(phase), 0);

    // Three periods back-to-back.
    do_reset();
    n0 = n_match;
    for (int k = 0; k < 3; k++) send_word(CODE, 1'b0);
    idle(3);
    chk("three_peaks", n_match - n0, 3);
    chk("three_locked", 32'(locked), 1);
    chk("three_phase", 32'(phase), 0);

    // All-zero chips: lock drops at the 46th chip after the peak.
    for (int k = 0; k < 45; k++) send(1'b0);
    idle(3);
    chk("zero45_locked", 32'(locked), 1);
    chk("zero45_phase", 32'(phase), 22);
    send(1'b0);
    idle(3);
    chk("zero46_locked", 32'(locked), 0);
    chk("zero46_score", 32'(score), 13);
    chk("zero46_phase", 32'(phase), 0);

    // Two flipped chips still match.
    do_reset();
    w = CODE ^ 23'h100010;
    send_word(w, 1'b0);
    idle(3);
    chk("flip2_score", 32'(score), 21);
    chk("flip2_locked", 32'(locked), 1);

    // Three flipped chips do not.
    do_reset();
    n0 = n_match;
    w = CODE ^ 23'h401001;
    send_word(w, 1'b0);
    idle(3);
    chk("flip3_score", 32'(score), 20);
    chk("flip3_locked", 32'(locked), 0);
    chk("flip3_peaks", n_match - n0, 0);

    // Idle gaps between chips.
    do_reset();
    n0 = n_match;
    send_word(CODE, 1'b1);
    idle(3);
    chk("gap_score", 32'(score), 23);
    chk("gap_peaks", n_match - n0, 1);
    chk("gap_locked", 32'(locked), 1);

    // Reset mid-frame discards received chips.
    do_reset();
    for (int i = N - 1; i > N - 11; i--) send(CODE[i]);
    do_reset();
    n0 = n_match;
    for (int i = N - 1; i > 0; i--) send(CODE[i]);
    idle(3);
    chk("mid_nopeak", n_match - n0, 0);
    chk("mid_score", 32'(score), 0);
    send(CODE[0]);
    idle(3);
    chk("mid_peak", n_match - n0, 1);
    chk("mid_score23", 32'(score), 23);

`ifdef WSLCE_INV_DET_EN
    // Inverted code word.
    do_reset();
    n0 = n_match;
    send_word(~CODE, 1'b0);
    idle(3);
    chk("inv_score", 32'(score), 0);
    chk("inv_pulses", n_inv, 1);
    chk("inv_nomatch", n_match - n0, 0);
    chk("inv_locked", 32'(locked), 1);
`endif

    idle(4);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
